dpram_march_bist: RTL and testbench

Built-in self-test controller for the 32x16 dual-port RAM. On `start` it drives the RAM's write port (`wr`/`waddr`/`d_in`) and read port (`rd`/`raddr`), then checks the returned `d_out` against a March X sequence. It reports pass/fail with the first failing address and the data actually read. It sits between the RAM and the system-level test/status logic and never drives the RAM's own `rst`.

---
 rtl/dpram_march_bist_if.sv | 25 ++
 rtl/dpram_march_bist.sv | 172 +++++++++++++++++
 tb/tb_dpram_march_bist.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dpram_march_bist_if.sv
// Memory-side bus between the March BIST controller and the 32x16 dual-port RAM.
//   mem_wr / mem_waddr / mem_din : RAM write port, driven by the BIST (master)
//   mem_rd / mem_raddr           : RAM read port, driven by the BIST (master)
//   mem_dout                     : RAM read data, driven by the RAM (slave)
interface dpram_march_bist_if #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 16
);
    logic          mem_wr;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_din;
    logic          mem_rd;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_dout;

    modport master (
        output mem_wr, mem_waddr, mem_din, mem_rd, mem_raddr,
        input  mem_dout
    );

    modport slave (
        input  mem_wr, mem_waddr, mem_din, mem_rd, mem_raddr,
        output mem_dout
    );
endinterface

// File: rtl/dpram_march_bist.sv
// March X built-in self-test controller for the 32x16 dual-port RAM.
// Runs M0 up W(PAT); M1 up R(PAT),W(~PAT); M2 down R(~PAT),W(PAT); M3 down R(PAT)
// and reports pass/fail with the first failing address and the data read there.
//   clk, rst_n            : clock, asynchronous active-low reset
//   start                 : begin a test (sampled only while idle)
//   busy / done / pass    : test running / one-cycle end pulse / result
//   fail_addr / fail_data : address and read data of the first mismatch
//   mem                   : RAM write/read ports and read data (interface, master side)
module dpram_march_bist #(
    parameter logic [15:0] PAT = 16'hAAAA
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [4:0]         fail_addr,
    output logic [15:0]        fail_data,
    dpram_march_bist_if.master mem
);
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 16;
    localparam logic [AW-1:0] ADDR_MAX = AW'(2 ** AW - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_M0,
        S_M1,
        S_M2,
        S_M3,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          phase_q, phase_d;      // 0: issue read, 1: compare (+ write in M1/M2)
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic [AW-1:0] fail_addr_q, fail_addr_d;
    logic [DW-1:0] fail_data_q, fail_data_d;
    logic          mem_wr_q, mem_wr_d;
    logic [AW-1:0] mem_waddr_q, mem_waddr_d;
    logic [DW-1:0] mem_din_q, mem_din_d;
    logic          mem_rd_q, mem_rd_d;
    logic [AW-1:0] mem_raddr_q, mem_raddr_d;
    logic [DW-1:0] exp_c;
    logic          mismatch_c;

    // Next state, plus next-cycle outputs decoded from the next state so every output is a flop
    always_comb begin : next_state
        state_d     = state_q;
        addr_d      = addr_q;
        phase_d     = phase_q;
        pass_d      = pass_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        exp_c       = (state_q == S_M2) ? ~PAT : PAT;
        mismatch_c  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_M0;
                    addr_d      = '0;
                    phase_d     = 1'b0;
                    pass_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_data_d = '0;
                end
            end
            S_M0: begin
                if (addr_q == ADDR_MAX) begin
                    state_d = S_M1;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
            S_M1, S_M2, S_M3: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d    = 1'b0;
                    mismatch_c = (mem.mem_dout != exp_c);
                    if (mismatch_c) begin
                        state_d     = S_DONE;
                        pass_d      = 1'b0;
                        fail_addr_d = addr_q;
                        fail_data_d = mem.mem_dout;
                    end else if (state_q == S_M1) begin
                        // M2 descends from the top address M1 just finished on
                        if (addr_q == ADDR_MAX) begin
                            state_d = S_M2;
                        end else begin
                            addr_d = addr_q + AW'(1);
                        end
                    end else if (addr_q == '0) begin
                        state_d = (state_q == S_M2) ? S_M3 : S_DONE;
                        addr_d  = ADDR_MAX;
                        pass_d  = (state_q == S_M3);
                    end else begin
                        addr_d = addr_q - AW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                addr_d  = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d      = state_d inside {S_M0, S_M1, S_M2, S_M3};
        done_d      = (state_d == S_DONE);
        mem_wr_d    = (state_d == S_M0) || ((state_d inside {S_M1, S_M2}) && phase_d);
        mem_rd_d    = (state_d inside {S_M1, S_M2, S_M3}) && !phase_d;
        mem_waddr_d = mem_wr_d ? addr_d : '0;
        mem_raddr_d = mem_rd_d ? addr_d : '0;
        mem_din_d   = '0;
        if (mem_wr_d) begin
            mem_din_d = (state_d == S_M1) ? ~PAT : PAT;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            phase_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            mem_wr_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_din_q   <= '0;
            mem_rd_q    <= 1'b0;
            mem_raddr_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            phase_q     <= phase_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            mem_wr_q    <= mem_wr_d;
            mem_waddr_q <= mem_waddr_d;
            mem_din_q   <= mem_din_d;
            mem_rd_q    <= mem_rd_d;
            mem_raddr_q <= mem_raddr_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign fail_addr     = fail_addr_q;
    assign fail_data     = fail_data_q;
    assign mem.mem_wr    = mem_wr_q;
    assign mem.mem_waddr = mem_waddr_q;
    assign mem.mem_din   = mem_din_q;
    assign mem.mem_rd    = mem_rd_q;
    assign mem.mem_raddr = mem_raddr_q;
endmodule

// File: tb/tb_dpram_march_bist.sv
// Bench for dpram_march_bist: two BIST instances (PAT=AAAA and PAT=0000), each with a
// behavioural RAM that can carry a stuck-at or write-flip fault. A March X reference model
// builds the expected per-cycle trace, write/read totals and fail record for every run.
module tb_dpram_march_bist;
    localparam logic [15:0] PAT0 = 16'hAAAA;
    localparam logic [15:0] PAT1 = 16'h0000;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        wr;
        logic [4:0]  waddr;
        logic [15:0] din;
        logic        rd;
        logic [4:0]  raddr;
    } cyc_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start     [2];
    logic        busy      [2];
    logic        done      [2];
    logic        pass      [2];
    logic [4:0]  fail_addr [2];
    logic [15:0] fail_data [2];
    logic        mon_wr    [2];
    logic        mon_rd    [2];
    logic [4:0]  mon_waddr [2];
    logic [4:0]  mon_raddr [2];
    logic [15:0] mon_din   [2];

    // Fault configuration: mode 0 none, 1 stuck-at-0, 2 stuck-at-1, 3 flip on nth write
    int f_mode [2];
    int f_addr [2];
    int f_bit  [2];
    int f_nth  [2];

    int checks = 0;
    int errors = 0;

    cyc_t        exp_q[$];
    logic        exp_fail;
    logic [4:0]  exp_faddr;
    logic [15:0] exp_fdata;
    int          exp_nwr;
    int          exp_nrd;

    always #5 clk = ~clk;

    // Value a faulty cell actually stores; wcnt counts writes to the faulty address
    function automatic logic [15:0] stored(input int mode, input int fa, input int fb,
                                           input int nth, input int a, input int wcnt,
                                           input logic [15:0] v);
        logic [15:0] m;
        m = 16'(1) << fb;
        if (a != fa) return v;
        case (mode)
            1:       return v & ~m;
            2:       return v | m;
            3:       return (wcnt == nth) ? (v ^ m) : v;
            default: return v;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam logic [15:0] P = (g == 0) ? PAT0 : PAT1;
        dpram_march_bist_if mem_if ();
        logic [15:0] memory [32];
        logic [15:0] dout_q;
        int          wr_seen;

        dpram_march_bist #(.PAT(P)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start[g]),
            .busy      (busy[g]),
            .done      (done[g]),
            .pass      (pass[g]),
            .fail_addr (fail_addr[g]),
            .fail_data (fail_data[g]),
            .mem       (mem_if.master)
        );

        // RAM: write has priority, read data appears the cycle after rd
        always @(posedge clk) begin
            if (!busy[g]) wr_seen <= 0;
            if (mem_if.mem_wr) begin
                memory[mem_if.mem_waddr] <= stored(f_mode[g], f_addr[g], f_bit[g], f_nth[g],
                    int'(mem_if.mem_waddr),
                    (int'(mem_if.mem_waddr) == f_addr[g]) ? wr_seen + 1 : wr_seen,
                    mem_if.mem_din);
                if (int'(mem_if.mem_waddr) == f_addr[g]) wr_seen <= wr_seen + 1;
            end else if (mem_if.mem_rd) begin
                dout_q <= memory[mem_if.mem_raddr];
            end
        end
        assign mem_if.mem_dout = dout_q;

        assign mon_wr[g]    = mem_if.mem_wr;
        assign mon_rd[g]    = mem_if.mem_rd;
        assign mon_waddr[g] = mem_if.mem_waddr;
        assign mon_raddr[g] = mem_if.mem_raddr;
        assign mon_din[g]   = mem_if.mem_din;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void push(input logic wr, input int wa, input logic [15:0] din,
                                 input logic rd, input int ra);
        cyc_t c;
        c.busy  = 1'b1;
        c.done  = 1'b0;
        c.wr    = wr;
        c.waddr = 5'(wa);
        c.din   = din;
        c.rd    = rd;
        c.raddr = 5'(ra);
        exp_q.push_back(c);
    endfunction

    // March X reference: element e in 0..3, one write cycle (M0) or read + write/compare cycles
    function automatic void build(input int g);
        logic [15:0] pat;
        logic [15:0] m [32];
        logic [15:0] got, expv, wv;
        int          a, wcnt;
        cyc_t        c;
        pat = (g == 0) ? PAT0 : PAT1;
        exp_q.delete();
        exp_fail = 1'b0; exp_faddr = '0; exp_fdata = '0;
        exp_nwr = 0; exp_nrd = 0; wcnt = 0; got = '0; expv = '0;
        for (int e = 0; e < 4 && !exp_fail; e++) begin
            for (int i = 0; i < 32 && !exp_fail; i++) begin
                a = (e < 2) ? i : 31 - i;
                if (e > 0) begin
                    push(1'b0, 0, 16'h0, 1'b1, a);
                    exp_nrd++;
                    got  = m[a];
                    expv = (e == 2) ? ~pat : pat;
                end
                if (e < 3) begin
                    wv = (e == 1) ? ~pat : pat;
                    push(1'b1, a, wv, 1'b0, 0);
                    exp_nwr++;
                    if (a == f_addr[g]) wcnt++;
                    m[a] = stored(f_mode[g], f_addr[g], f_bit[g], f_nth[g], a, wcnt, wv);
                end else begin
                    push(1'b0, 0, 16'h0, 1'b0, 0);
                end
                if (e > 0 && got !== expv) begin
                    exp_fail  = 1'b1;
                    exp_faddr = 5'(a);
                    exp_fdata = got;
                end
            end
        end
        c = '0;
        c.done = 1'b1;
        exp_q.push_back(c);
    endfunction

    // One test run; p1/p2 are cycles at which start is re-pulsed (negative = random)
    task automatic run(input int g, input int p1, input int p2);
        int L, nwr, nrd;
        build(g);
        L = exp_q.size();
        if (p1 < 0) p1 = int'($urandom_range(L - 1, 2));
        if (p2 < 0) p2 = int'($urandom_range(L - 1, 2));
        nwr = 0; nrd = 0;
        @(negedge clk);
        start[g] = 1'b1;
        for (int k = 1; k <= L + 1; k++) begin
            @(negedge clk);
            start[g] = (k == p1) || (k == p2);
            nwr += int'(mon_wr[g]);
            nrd += int'(mon_rd[g]);
            chk($sformatf("i%0d_cyc%0d", g, k),
                64'({busy[g], done[g], mon_wr[g], mon_waddr[g], mon_din[g], mon_rd[g], mon_raddr[g]}),
                (k <= L) ? 64'(exp_q[k-1]) : 64'(0));
            if (k >= L) chk($sformatf("i%0d_pass%0d", g, k), 64'(pass[g]), 64'(!exp_fail));
            if (k == L && exp_fail) begin
                chk($sformatf("i%0d_fail_addr", g), 64'(fail_addr[g]), 64'(exp_faddr));
                chk($sformatf("i%0d_fail_data", g), 64'(fail_data[g]), 64'(exp_fdata));
            end
        end
        chk($sformatf("i%0d_wr_count", g), 64'(nwr), 64'(exp_nwr));
        chk($sformatf("i%0d_rd_count", g), 64'(nrd), 64'(exp_nrd));
    endtask

    task automatic chk_idle(input string tag, input int g);
        chk(tag, 64'({busy[g], done[g], pass[g], fail_addr[g], fail_data[g],
                      mon_wr[g], mon_waddr[g], mon_din[g], mon_rd[g], mon_raddr[g]}), 64'(0));
    endtask

    initial begin
        rst_n = 1'b0;
        for (int g = 0; g < 2; g++) begin
            start[g] = 1'b0; f_mode[g] = 0; f_addr[g] = 0; f_bit[g] = 0; f_nth[g] = 0;
        end
        #12;
        chk_idle("reset_i0", 0);
        chk_idle("reset_i1", 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Fault-free run with start re-pulsed at cycles 10 and 100
        run(0, 10, 100);

        // Stuck-at-0 on memory[5] bit 3 caught in M1
        f_mode[0] = 1; f_addr[0] = 5; f_bit[0] = 3;
        run(0, 0, 0);
        chk("sa0_fail_addr", 64'(fail_addr[0]), 64'(5));
        chk("sa0_fail_data", 64'(fail_data[0]), 64'(16'hAAA2));
        chk("sa0_pass", 64'(pass[0]), 64'(0));

        // PAT=0000, memory[31] bit 15 flipped by its M2 write, caught first thing in M3
        f_mode[1] = 3; f_addr[1] = 31; f_bit[1] = 15; f_nth[1] = 3;
        run(1, 0, 0);
        chk("flip_fail_addr", 64'(fail_addr[1]), 64'(31));
        chk("flip_fail_data", 64'(fail_data[1]), 64'(16'h8000));

        // Asynchronous reset in the middle of cycle 70
        f_mode[0] = 0;
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (68) @(negedge clk);
        chk("pre_rst_busy", 64'(busy[0]), 64'(1));
        chk("pre_rst_rd", 64'(mon_rd[0]), 64'(1));
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_idle("mid_rst_i0", 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(0, -1, -1);

        // Randomized fault type/location/pattern instance and start re-pulses
        for (int r = 0; r < 8; r++) begin
            int g;
            g = int'($urandom_range(1, 0));
            f_mode[g] = int'($urandom_range(3, 0));
            f_addr[g] = int'($urandom_range(31, 0));
            f_bit[g]  = int'($urandom_range(15, 0));
            f_nth[g]  = int'($urandom_range(3, 1));
            run(g, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
